tx_ser_ctrl_xxpad: RTL and testbench

Per-pad transmit serializer and mode sequencer sitting directly upstream of the pad driver-enable logic. Accepts parallel words over a valid/ready handshake, serializes them LSB-first onto the pad `data` line, and drives the `tx_en` and `tx_async_en` controls with a fixed low preamble before traffic begins. It completes the in-flight word on shutdown and provides an asynchronous bypass path. Mode straps (`sdr_mode_en`, `gen1_en`) pass to the driver-enable logic unchanged; this block uses `sdr_mode_en` only to set bit hold time.

---
 rtl/tx_ser_ctrl_xxpad.sv | 160 ++++++++++++++++
 tb/tb_tx_ser_ctrl_xxpad.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tx_ser_ctrl_xxpad.sv
// Per-pad transmit serializer and mode sequencer ahead of the pad driver-enable logic.
// Emits a low preamble, then shifts parallel words out LSB-first. It also offers an
// asynchronous bypass path.
module tx_ser_ctrl_xxpad #(
   parameter int unsigned SER_W   = 4,
   parameter int unsigned PRE_CYC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_req,
   input  logic             sdr_mode_en,
   input  logic             async_en,
   input  logic             async_data,
   input  logic [SER_W-1:0] word_data,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             data,
   output logic             tx_en,
   output logic             tx_async_en,
   output logic             busy,
   output logic             underrun
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned BIDX_W = (SER_W > 2) ? $clog2(SER_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_RUN   = 2'd2,
      ST_ASYNC = 2'd3
   } state_t;

   state_t              state_q, state_nxt;
   logic [CNT_W-1:0]    pre_cnt_q, pre_cnt_nxt;
   logic                hold2_q, hold2_nxt;
   logic                hcnt_q, hcnt_nxt;
   logic [BIDX_W-1:0]   bidx_q, bidx_nxt;
   logic [SER_W-1:0]    shreg_q, shreg_nxt;
   logic                data_nxt, tx_en_nxt, tx_async_en_nxt, underrun_nxt;

   logic                pre_done_c;
   logic                bit_end_c;
   logic                last_slot_c;

   // Slot decode: end of preamble, end of a bit period, and the final bit of a word.
   always_comb begin
      pre_done_c  = (state_q == ST_PRE) && (pre_cnt_q == '0);
      bit_end_c   = (state_q == ST_RUN) && (hold2_q ? hcnt_q : 1'b1);
      last_slot_c = bit_end_c && (bidx_q == BIDX_W'(SER_W - 1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic; async bypass wins over a serial request in IDLE.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (async_en) begin
               state_nxt = ST_ASYNC;
            end else if (tx_req) begin
               state_nxt = ST_PRE;
            end
         end
         ST_PRE: begin
            if (pre_done_c) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_slot_c && !tx_req) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ASYNC: begin
            if (!async_en) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output and datapath next values; registered outputs follow the next state.
   always_comb begin
      word_ready      = pre_done_c || (last_slot_c && tx_req);
      busy            = (state_q != ST_IDLE);
      pre_cnt_nxt     = pre_cnt_q;
      hold2_nxt       = hold2_q;
      hcnt_nxt        = hcnt_q;
      bidx_nxt        = bidx_q;
      shreg_nxt       = shreg_q;
      underrun_nxt    = word_ready && !word_valid;

      // Mode strap and preamble length are captured only when leaving IDLE for PRE.
      if ((state_q == ST_IDLE) && !async_en && tx_req) begin
         pre_cnt_nxt = CNT_W'(PRE_CYC - 1);
         hold2_nxt   = sdr_mode_en;
      end else if ((state_q == ST_PRE) && !pre_done_c) begin
         pre_cnt_nxt = pre_cnt_q - CNT_W'(1);
      end

      if (word_ready) begin
         shreg_nxt = word_valid ? word_data : '0;
         bidx_nxt  = '0;
         hcnt_nxt  = 1'b0;
      end else if (last_slot_c) begin
         bidx_nxt  = '0;
         hcnt_nxt  = 1'b0;
      end else if (bit_end_c) begin
         shreg_nxt = shreg_q >> 1;
         bidx_nxt  = bidx_q + BIDX_W'(1);
         hcnt_nxt  = 1'b0;
      end else if (state_q == ST_RUN) begin
         hcnt_nxt  = 1'b1;
      end

      tx_en_nxt       = (state_nxt == ST_PRE) || (state_nxt == ST_RUN);
      tx_async_en_nxt = (state_nxt == ST_ASYNC);
      unique case (state_nxt)
         ST_RUN:   data_nxt = shreg_nxt[0];
         ST_ASYNC: data_nxt = async_data;
         default:  data_nxt = 1'b0;
      endcase
   end

   // Datapath and registered pad-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q   <= '0;
         hold2_q     <= 1'b0;
         hcnt_q      <= 1'b0;
         bidx_q      <= '0;
         shreg_q     <= '0;
         data        <= 1'b0;
         tx_en       <= 1'b0;
         tx_async_en <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         pre_cnt_q   <= pre_cnt_nxt;
         hold2_q     <= hold2_nxt;
         hcnt_q      <= hcnt_nxt;
         bidx_q      <= bidx_nxt;
         shreg_q     <= shreg_nxt;
         data        <= data_nxt;
         tx_en       <= tx_en_nxt;
         tx_async_en <= tx_async_en_nxt;
         underrun    <= underrun_nxt;
      end
   end

endmodule

// File: tb/tb_tx_ser_ctrl_xxpad.sv
// Directed bench for tx_ser_ctrl_xxpad (SER_W=4, PRE_CYC=8).
module tb_tx_ser_ctrl_xxpad;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_req, sdr_mode_en, async_en, async_data, word_valid;
   logic [3:0] word_data;
   logic       word_ready, data, tx_en, tx_async_en, busy, underrun;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   tx_ser_ctrl_xxpad #(.SER_W(4), .PRE_CYC(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_req      (tx_req),
      .sdr_mode_en (sdr_mode_en),
      .async_en    (async_en),
      .async_data  (async_data),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .data        (data),
      .tx_en       (tx_en),
      .tx_async_en (tx_async_en),
      .busy        (busy),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   // Single comparison point.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check one cycle of serial outputs, then advance past the next edge.
   task automatic cyc(input string tag, input logic e_data, input logic e_txen,
                      input logic e_wr, input logic e_ur);
      #1;
      chk({tag, ".data"}, 32'(data), 32'(e_data));
      chk({tag, ".tx_en"}, 32'(tx_en), 32'(e_txen));
      chk({tag, ".word_ready"}, 32'(word_ready), 32'(e_wr));
      chk({tag, ".underrun"}, 32'(underrun), 32'(e_ur));
      chk({tag, ".excl"}, 32'(tx_en & tx_async_en), 32'd0);
      tick();
   endtask

   task automatic all_zero(input string tag);
      chk({tag, ".data"}, 32'(data), 32'd0);
      chk({tag, ".tx_en"}, 32'(tx_en), 32'd0);
      chk({tag, ".tx_async_en"}, 32'(tx_async_en), 32'd0);
      chk({tag, ".word_ready"}, 32'(word_ready), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".underrun"}, 32'(underrun), 32'd0);
   endtask

   initial begin
      logic [3:0] w;
      logic [7:0] e;

      rst_n = 1'b1; tx_req = 1'b0; sdr_mode_en = 1'b0; async_en = 1'b0;
      async_data = 1'b0; word_valid = 1'b0; word_data = 4'h0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 all_zero("rst");
      @(negedge clk) rst_n = 1'b1;
      tick();
      #1 all_zero("rst_rel");

      // Gen serial: 4'hA then 4'h3, tx_req dropped during second word.
      tx_req = 1'b1; word_valid = 1'b1; word_data = 4'hA;
      tick();
      for (int i = 0; i < 8; i++) cyc("gen_pre", 1'b0, 1'b1, i == 7, 1'b0);
      word_data = 4'h3;
      w = 4'hA;
      for (int j = 0; j < 4; j++) cyc("gen_w0", w[j], 1'b1, j == 3, 1'b0);
      w = 4'h3;
      for (int j = 0; j < 4; j++) begin
         if (j == 1) tx_req = 1'b0;
         cyc("gen_w1", w[j], 1'b1, 1'b0, 1'b0);
      end
      all_zero("gen_end");

      // Reset between edges in the middle of RUN.
      tx_req = 1'b1; word_data = 4'h5;
      tick();
      for (int i = 0; i < 8; i++) cyc("rr_pre", 1'b0, 1'b1, i == 7, 1'b0);
      cyc("rr_b0", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("rr_b1", 1'b0, 1'b1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 all_zero("rr_async");
      tx_req = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         #1 all_zero("rr_post");
         tick();
      end

      // SDR hold with mid-session sdr/async changes; word 4'b0110.
      sdr_mode_en = 1'b1; tx_req = 1'b1; word_valid = 1'b1; word_data = 4'b0110;
      tick();
      for (int i = 0; i < 8; i++) cyc("sdr_pre", 1'b0, 1'b1, i == 7, 1'b0);
      e = 8'b0011_1100;
      for (int wi = 0; wi < 3; wi++) begin
         for (int k = 0; k < 8; k++) begin
            if (wi == 1 && k == 3) begin
               sdr_mode_en = 1'b0;
               async_en    = 1'b1;
            end
            if (wi == 2 && k == 2) tx_req = 1'b0;
            cyc("sdr_run", e[k], 1'b1, (k == 7) && (wi < 2), 1'b0);
         end
      end
      #1 all_zero("sdr_end");
      tick();
      #1 chk("sdr_async.tx_async_en", 32'(tx_async_en), 32'd1);
      chk("sdr_async.tx_en", 32'(tx_en), 32'd0);
      async_en = 1'b0;
      tick();
      #1 chk("sdr_async_off", 32'(tx_async_en), 32'd0);

      // Underrun at second slot.
      tx_req = 1'b1; word_valid = 1'b1; word_data = 4'hF;
      tick();
      for (int i = 0; i < 8; i++) cyc("ur_pre", 1'b0, 1'b1, i == 7, 1'b0);
      word_valid = 1'b0;
      for (int j = 0; j < 4; j++) cyc("ur_w0", 1'b1, 1'b1, j == 3, 1'b0);
      tx_req = 1'b0;
      for (int j = 0; j < 4; j++) cyc("ur_w1", 1'b0, 1'b1, 1'b0, j == 0);
      word_valid = 1'b1;
      #1 all_zero("ur_end");

      // Async priority over tx_req in the same IDLE cycle.
      async_en = 1'b1; tx_req = 1'b1; async_data = 1'b0;
      tick();
      #1 chk("as.tx_async_en", 32'(tx_async_en), 32'd1);
      chk("as.tx_en", 32'(tx_en), 32'd0);
      chk("as.busy", 32'(busy), 32'd1);
      chk("as.data0", 32'(data), 32'd0);
      async_data = 1'b1;
      #1 chk("as.data_lat", 32'(data), 32'd0);
      tick();
      #1 chk("as.data1", 32'(data), 32'd1);
      async_data = 1'b0;
      tick();
      #1 chk("as.data2", 32'(data), 32'd0);
      async_en = 1'b0;
      tick();
      #1 chk("as_off.tx_async_en", 32'(tx_async_en), 32'd0);
      chk("as_off.tx_en", 32'(tx_en), 32'd0);
      chk("as_off.busy", 32'(busy), 32'd0);
      tick();
      #1 chk("as_pre.tx_en", 32'(tx_en), 32'd1);
      chk("as_pre.tx_async_en", 32'(tx_async_en), 32'd0);
      tx_req = 1'b0;
      for (int i = 0; i < 40 && busy; i++) tick();
      #1 chk("as_drain.busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
